cmos_dvp_capture: RTL and testbench



---
 rtl/cmos_dvp_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_cmos_dvp_capture.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_dvp_capture.sv
// rtl/cmos_dvp_capture.sv - DVP camera byte bus capture into framed RGB565 pixel stream
//
// Purpose: samples the 8-bit DVP bus (vsync/href/data) in the pixel clock
// domain, skips SKIP_FRAMES settling frames after enable, pairs bytes into
// 16-bit pixels and emits them with sof/eol framing. Reports a per-frame
// geometry error flag and a completed-frame count.
//
// Ports:
//   cmos_pclk_i    pixel clock (only clock)
//   rst_i          asynchronous active-high reset
//   cmos_vsync_i   frame sync, high during vertical sync
//   cmos_href_i    line valid
//   cmos_data_i    byte bus, valid while href is high
//   enable_i       capture request, acted on at frame boundaries
//   pix_data_o     assembled pixel, held between strobes
//   pix_valid_o    one-cycle strobe per pixel
//   pix_sof_o      first pixel of a captured frame
//   pix_eol_o      pixel index H_ACTIVE-1 of a line
//   frame_done_o   end of each captured frame
//   frame_err_o    geometry error flag, valid with frame_done_o
//   frame_cnt_o    completed captured frames (wraps)
//   line_cnt_o     lines completed in the current captured frame (saturates)
module cmos_dvp_capture #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int SKIP_FRAMES = 10,
  parameter bit BYTE_SWAP   = 1'b0
) (
  input  logic        cmos_pclk_i,
  input  logic        rst_i,
  input  logic        cmos_vsync_i,
  input  logic        cmos_href_i,
  input  logic [7:0]  cmos_data_i,
  input  logic        enable_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [7:0]  frame_cnt_o,
  output logic [11:0] line_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_FRAME, S_VBLANK} state_t;

  state_t      state_q, state_d;
  logic        vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0]  d_q;
  logic [15:0] skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [7:0]  held_q, held_d;
  // One bit wider than H_ACTIVE so an over-long line still reads != H_ACTIVE.
  logic [12:0] px_q, px_d;
  logic [11:0] line_q, line_d;
  logic        err_q, err_d;
  logic        sof_pend_q, sof_pend_d;

  // Stage 1: pixel/frame events decided from the registered bus.
  logic [15:0] s1_data_q, s1_data_d;
  logic        s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
  logic        s1_done_q, s1_done_d, s1_err_q, s1_err_d;

  // Stage 2: output registers.
  logic [15:0] pix_data_q;
  logic        pix_valid_q, pix_sof_q, pix_eol_q, done_q, ferr_q;
  logic [7:0]  fcnt_q;

  logic frame_start, frame_end, hr_rise, hr_fall, active;

  assign frame_start = vs_qq & ~vs_q;
  assign frame_end   = vs_q & ~vs_qq;
  assign hr_rise     = hr_q & ~hr_qq;
  assign hr_fall     = hr_qq & ~hr_q;
  assign active      = (state_q == S_FRAME) && !vs_q;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    phase_d    = phase_q;
    held_d     = held_q;
    px_d       = px_q;
    line_d     = line_q;
    err_d      = err_q;
    sof_pend_d = sof_pend_q;
    s1_data_d  = s1_data_q;
    s1_valid_d = 1'b0;
    s1_sof_d   = 1'b0;
    s1_eol_d   = 1'b0;
    s1_done_d  = 1'b0;
    s1_err_d   = 1'b0;

    // Byte pairing; phase returns to 0 whenever href is low, which also
    // discards a dangling first byte of an odd-length line.
    if (active && hr_q) begin
      if (!phase_q) begin
        held_d  = d_q;
        phase_d = 1'b1;
        if (hr_rise) px_d = '0;
      end else begin
        phase_d = 1'b0;
        if (px_q < 13'(H_ACTIVE)) begin
          s1_valid_d = 1'b1;
          s1_data_d  = BYTE_SWAP ? {d_q, held_q} : {held_q, d_q};
          s1_sof_d   = sof_pend_q;
          s1_eol_d   = (px_q == 13'(H_ACTIVE - 1));
          sof_pend_d = 1'b0;
        end
        if (px_q <= 13'(H_ACTIVE)) px_d = px_q + 13'd1;
      end
    end else begin
      phase_d = 1'b0;
      if (active && hr_fall) begin
        if (line_q != 12'hFFF) line_d = line_q + 12'd1;
        if (px_q != 13'(H_ACTIVE) || phase_q) err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_SYNC;
          skip_d  = '0;
        end
      end
      S_SYNC: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          if (skip_q == 16'(SKIP_FRAMES)) begin
            state_d    = S_FRAME;
            line_d     = '0;
            err_d      = 1'b0;
            sof_pend_d = 1'b1;
            px_d       = '0;
          end else begin
            skip_d = skip_q + 16'd1;
          end
        end
      end
      S_FRAME: begin
        if (frame_end) begin
          s1_done_d = 1'b1;
          s1_err_d  = err_q | (line_q != 12'(V_ACTIVE));
          state_d   = enable_i ? S_VBLANK : S_IDLE;
        end
      end
      default: begin  // S_VBLANK
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          state_d    = S_FRAME;
          line_d     = '0;
          err_d      = 1'b0;
          sof_pend_d = 1'b1;
          px_d       = '0;
        end
      end
    endcase
  end

  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      hr_q        <= 1'b0;
      hr_qq       <= 1'b0;
      d_q         <= '0;
      state_q     <= S_IDLE;
      skip_q      <= '0;
      phase_q     <= 1'b0;
      held_q      <= '0;
      px_q        <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      sof_pend_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_done_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      vs_q        <= cmos_vsync_i;
      vs_qq       <= vs_q;
      hr_q        <= cmos_href_i;
      hr_qq       <= hr_q;
      d_q         <= cmos_data_i;
      state_q     <= state_d;
      skip_q      <= skip_d;
      phase_q     <= phase_d;
      held_q      <= held_d;
      px_q        <= px_d;
      line_q      <= line_d;
      err_q       <= err_d;
      sof_pend_q  <= sof_pend_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      s1_done_q   <= s1_done_d;
      s1_err_q    <= s1_err_d;
      if (s1_valid_q) pix_data_q <= s1_data_q;
      pix_valid_q <= s1_valid_q;
      pix_sof_q   <= s1_sof_q;
      pix_eol_q   <= s1_eol_q;
      done_q      <= s1_done_q;
      ferr_q      <= s1_err_q;
      if (s1_done_q) fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign pix_data_o   = pix_data_q;
  assign pix_valid_o  = pix_valid_q;
  assign pix_sof_o    = pix_sof_q;
  assign pix_eol_o    = pix_eol_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = ferr_q;
  assign frame_cnt_o  = fcnt_q;
  assign line_cnt_o   = line_q;

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// tb/tb_cmos_dvp_capture.sv - scoreboard bench for cmos_dvp_capture
module tb_cmos_dvp_capture;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct {
    logic [15:0] data;
    bit          sof;
    bit          eol;
    int          t_in;
  } pix_t;

  typedef struct {
    bit         err;
    logic [7:0] cnt;
  } frm_t;

  logic        clk, rst, vs, hr, en;
  logic [7:0]  dat;
  logic [15:0] pix_data, sw_data;
  logic        pix_valid, pix_sof, pix_eol, fdone, ferr;
  logic        sw_valid, sw_sof, sw_eol, sw_fdone, sw_ferr;
  logic [7:0]  fcnt, sw_fcnt;
  logic [11:0] lcnt, sw_lcnt;

  pix_t pix_q[$];
  frm_t frm_q[$];
  int   asserts = 0;
  int   fails = 0;
  int   cyc = 0;
  int   nvalid = 0, neol = 0, nsof = 0, ndone = 0;
  logic [7:0]  exp_fcnt = 0;
  logic [15:0] first_pix = 0, first_pix_sw = 0;

  cmos_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(1), .BYTE_SWAP(1'b0)) dut (
    .cmos_pclk_i(clk), .rst_i(rst), .cmos_vsync_i(vs), .cmos_href_i(hr),
    .cmos_data_i(dat), .enable_i(en), .pix_data_o(pix_data), .pix_valid_o(pix_valid),
    .pix_sof_o(pix_sof), .pix_eol_o(pix_eol), .frame_done_o(fdone), .frame_err_o(ferr),
    .frame_cnt_o(fcnt), .line_cnt_o(lcnt));

  cmos_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(1), .BYTE_SWAP(1'b1)) dut_sw (
    .cmos_pclk_i(clk), .rst_i(rst), .cmos_vsync_i(vs), .cmos_href_i(hr),
    .cmos_data_i(dat), .enable_i(en), .pix_data_o(sw_data), .pix_valid_o(sw_valid),
    .pix_sof_o(sw_sof), .pix_eol_o(sw_eol), .frame_done_o(sw_fdone), .frame_err_o(sw_ferr),
    .frame_cnt_o(sw_fcnt), .line_cnt_o(sw_lcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard whenever the DUT produces something.
  always @(negedge clk) begin
    pix_t it;
    frm_t fr;
    if (!rst) begin
      if (pix_valid) begin
        nvalid++;
        if (pix_eol) neol++;
        if (pix_sof) begin
          nsof++;
          first_pix    = pix_data;
          first_pix_sw = sw_data;
        end
        asserts++;
        if (pix_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pixel: got data=%h with no pixel expected", pix_data);
        end else begin
          it = pix_q.pop_front();
          asserts++;
          if (pix_data !== it.data) begin
            fails++;
            $display("FAIL pix_data: got %h expected %h", pix_data, it.data);
          end
          asserts++;
          if (sw_valid !== 1'b1 || sw_data !== {it.data[7:0], it.data[15:8]}) begin
            fails++;
            $display("FAIL pix_data_swap: got valid=%b data=%h expected %h", sw_valid, sw_data,
                     {it.data[7:0], it.data[15:8]});
          end
          asserts++;
          if (pix_sof !== it.sof || pix_eol !== it.eol) begin
            fails++;
            $display("FAIL sof_eol: got sof=%b eol=%b expected sof=%b eol=%b", pix_sof, pix_eol,
                     it.sof, it.eol);
          end
          asserts++;
          if (cyc - it.t_in != 2) begin
            fails++;
            $display("FAIL pix_latency: got %0d edges expected 2", cyc - it.t_in);
          end
        end
      end
      if (fdone) begin
        ndone++;
        asserts++;
        if (frm_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: frame_done_o with no frame expected");
        end else begin
          fr = frm_q.pop_front();
          asserts++;
          if (ferr !== fr.err || fcnt !== fr.cnt || lcnt !== 12'(V)) begin
            fails++;
            $display("FAIL frame_done: got err=%b cnt=%0d lines=%0d expected err=%b cnt=%0d lines=%0d",
                     ferr, fcnt, lcnt, fr.err, fr.cnt, V);
          end
        end
      end
    end
  end

  // One frame: vsync falls, V lines of href, vsync rises. Expected pixels and
  // frame results are pushed as the bytes are driven.
  task automatic drive_frame(input bit cap, input logic [7:0] a0, input logic [7:0] a1,
                             input int bad_line, input int bad_bytes, input int drop_line);
    int          nb;
    bit          ferr_exp, first;
    logic [7:0]  b, held;
    pix_t        p;
    frm_t        f;
    ferr_exp = 0;
    first    = 1;
    held     = 0;
    @(negedge clk); vs = 0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < V; l++) begin
      nb = (l == bad_line) ? bad_bytes : 2 * H;
      if (nb != 2 * H) ferr_exp = 1;
      for (int i = 0; i < nb; i++) begin
        if (l == 0 && i == 0) b = a0;
        else if (l == 0 && i == 1) b = a1;
        else b = 8'($urandom);
        @(negedge clk); hr = 1; dat = b;
        if (l == drop_line && i == 2) en = 0;
        if (i % 2 == 0) held = b;
        else if (cap && (i / 2) < H) begin
          p.data = {held, b};
          p.sof  = first;
          p.eol  = ((i / 2) == H - 1);
          p.t_in = cyc + 1;
          pix_q.push_back(p);
          first = 0;
        end
      end
      @(negedge clk); hr = 0; dat = 8'($urandom);
      repeat (2) @(negedge clk);
    end
    @(negedge clk); vs = 1;
    if (cap) begin
      exp_fcnt = exp_fcnt + 8'd1;
      f.err = ferr_exp;
      f.cnt = exp_fcnt;
      frm_q.push_back(f);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; vs = 1; hr = 0; dat = 0; en = 1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({pix_data, pix_valid, pix_sof, pix_eol, fdone, ferr, fcnt, lcnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h v=%b sof=%b eol=%b done=%b err=%b fcnt=%0d lcnt=%0d expected all 0",
               pix_data, pix_valid, pix_sof, pix_eol, fdone, ferr, fcnt, lcnt);
    end
    rst = 0;
    repeat (3) @(negedge clk);
    asserts++;
    if (pix_valid !== 1'b0 || fcnt !== 8'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got valid=%b fcnt=%0d expected 0 0", pix_valid, fcnt);
    end
  endtask

  task automatic test_skip_and_capture;
    int v0, e0, s0;
    v0 = nvalid;
    drive_frame(0, 8'h11, 8'h22, -1, 0, -1);
    asserts++;
    if (nvalid != v0 || ndone != 0) begin
      fails++;
      $display("FAIL skip_frame_silent: got %0d pixels %0d done expected 0 0", nvalid - v0, ndone);
    end
    v0 = nvalid; e0 = neol; s0 = nsof;
    drive_frame(1, 8'h33, 8'h44, -1, 0, -1);
    asserts++;
    if (nvalid - v0 != H * V || neol - e0 != V || nsof - s0 != 1) begin
      fails++;
      $display("FAIL capture_counts: got pix=%0d eol=%0d sof=%0d expected %0d %0d 1",
               nvalid - v0, neol - e0, nsof - s0, H * V, V);
    end
    asserts++;
    if (fcnt !== 8'd1) begin
      fails++;
      $display("FAIL frame_cnt_first: got %0d expected 1", fcnt);
    end
  endtask

  task automatic test_byte_order;
    drive_frame(1, 8'hA1, 8'hB2, -1, 0, -1);
    asserts++;
    if (first_pix !== 16'hA1B2) begin
      fails++;
      $display("FAIL byte_order: got %h expected a1b2", first_pix);
    end
    asserts++;
    if (first_pix_sw !== 16'hB2A1) begin
      fails++;
      $display("FAIL byte_order_swap: got %h expected b2a1", first_pix_sw);
    end
  endtask

  task automatic test_short_line;
    int e0;
    e0 = neol;
    drive_frame(1, 8'h01, 8'h02, 1, 6, -1);
    asserts++;
    if (neol - e0 != V - 1) begin
      fails++;
      $display("FAIL short_line_eol: got %0d eol expected %0d", neol - e0, V - 1);
    end
    drive_frame(1, 8'h03, 8'h04, -1, 0, -1);
  endtask

  task automatic test_long_line;
    int v0, e0;
    v0 = nvalid; e0 = neol;
    drive_frame(1, 8'h05, 8'h06, 2, 9, -1);
    asserts++;
    if (nvalid - v0 != H * V || neol - e0 != V) begin
      fails++;
      $display("FAIL long_line_counts: got pix=%0d eol=%0d expected %0d %0d",
               nvalid - v0, neol - e0, H * V, V);
    end
  endtask

  task automatic test_enable_drop;
    int v0, d0;
    v0 = nvalid;
    drive_frame(1, 8'h07, 8'h08, -1, 0, 1);
    asserts++;
    if (nvalid - v0 != H * V) begin
      fails++;
      $display("FAIL enable_drop_frame: got %0d pixels expected %0d", nvalid - v0, H * V);
    end
    v0 = nvalid; d0 = ndone;
    drive_frame(0, 8'h09, 8'h0A, -1, 0, -1);
    asserts++;
    if (nvalid != v0 || ndone != d0 || fcnt !== exp_fcnt) begin
      fails++;
      $display("FAIL disabled_frame: got pix=%0d done=%0d fcnt=%0d expected 0 0 %0d",
               nvalid - v0, ndone - d0, fcnt, exp_fcnt);
    end
  endtask

  task automatic test_reset_mid_line;
    int v0;
    en = 1;
    drive_frame(0, 8'h10, 8'h20, -1, 0, -1);
    // Captured frame interrupted by reset at the start of line 1.
    @(negedge clk); vs = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2 * H; i++) begin
      @(negedge clk); hr = 1; dat = 8'(i + 8'h40);
      if (i % 2 == 1) pix_q.push_back('{data: {8'(i - 1 + 8'h40), 8'(i + 8'h40)},
                                          sof: (i == 1), eol: (i == 2 * H - 1), t_in: cyc + 1});
    end
    @(negedge clk); hr = 0;
    repeat (3) @(negedge clk);
    @(negedge clk); hr = 1; dat = 8'h5A;
    @(negedge clk); dat = 8'h6B; rst = 1;
    #1;
    asserts++;
    if ({pix_data, pix_valid, pix_sof, pix_eol, fdone, ferr, fcnt, lcnt} !== '0) begin
      fails++;
      $display("FAIL reset_mid_line: got data=%h v=%b done=%b fcnt=%0d lcnt=%0d expected all 0",
               pix_data, pix_valid, fdone, fcnt, lcnt);
    end
    asserts++;
    if (pix_q.size() != 0) begin
      fails++;
      $display("FAIL pixels_before_reset: got %0d pending expected 0", pix_q.size());
    end
    pix_q.delete();
    frm_q.delete();
    exp_fcnt = 0;
    @(negedge clk); rst = 0; hr = 0;
    repeat (4) @(negedge clk);
    vs = 1;
    repeat (4) @(negedge clk);
    v0 = nvalid;
    drive_frame(0, 8'h11, 8'h12, -1, 0, -1);
    asserts++;
    if (nvalid != v0) begin
      fails++;
      $display("FAIL reskip_after_reset: got %0d pixels expected 0", nvalid - v0);
    end
    drive_frame(1, 8'h13, 8'h14, -1, 0, -1);
    asserts++;
    if (nvalid - v0 != H * V || fcnt !== 8'd1) begin
      fails++;
      $display("FAIL resume_after_reset: got pix=%0d fcnt=%0d expected %0d 1", nvalid - v0, fcnt, H * V);
    end
  endtask

  initial begin
    test_reset();
    test_skip_and_capture();
    test_byte_order();
    test_short_line();
    test_long_line();
    test_enable_drop();
    test_reset_mid_line();
    repeat (4) @(negedge clk);
    asserts++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pixels %0d frames left expected 0 0",
               pix_q.size(), frm_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
